tt_um_priority_decoder: RTL and testbench
=========================================

Name: tt_um_priority_decoder

Overview:
- Companion to the team's 16-bit priority encoder: accepts the encoder's 8-bit code (index 0-15, or 0xF0 = "no bit set") and rebuilds a registered 16-bit one-hot or accumulated bit mask.
- Host strobes codes in over a pin-level handshake. Each code is applied to the mask by one of four operations.
- The mask is read back one byte at a time, and status flags are driven on uio.

Parameters:
SYNC_STAGES, 2, number of flops in the strobe synchronizer; legal range 2..3.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, strobes are not accepted
ui_in  input  8  code: 0x00-0x0F = bit index, 0xF0 = none, any other value is illegal
uio_in  input  8  [0] strobe, [2:1] op, [3] byte select, [7:4] unused
uio_out  output  8  [3:0]=0, [4] ack, [5] ack_toggle, [6] mask_zero, [7] err
uio_oe  output  8  constant 0xF0
uo_out  output  8  selected mask byte

Behaviour:
- Reset (async assert, sync-free release handled by flops):
  - mask=0x0000, all sync flops=0, delay flop=0.
  - ack=0, ack_toggle=0, err=0, hence mask_zero=1.
  - uo_out=0x00.
- Strobe path:
  - uio_in[0] passes through SYNC_STAGES flops, then one delay flop.
  - rise = last sync stage AND NOT delay flop.
  - Strobe first sampled high at edge 0 -> rise is high during the cycle after edge SYNC_STAGES-1 -> update occurs at edge SYNC_STAGES.
- Code and op are sampled directly, unsynchronized, at the update edge. The host must hold them stable from strobe rise until it sees ack.
- Accept condition: rise AND ena. If ena is low, the rise is consumed but ignored: no update and no ack.
- Operations on accept, with legal index i (onehot = 1<<i):
  - op 00 SET: mask |= onehot.
  - op 01 CLEAR: mask &= ~onehot.
  - op 10 TOGGLE: mask ^= onehot.
  - op 11 LOAD: mask = onehot.
- Code 0xF0 on accept:
  - LOAD: mask = 0x0000 and err is cleared.
  - SET, CLEAR, TOGGLE: mask unchanged.
  - Counts as legal.
- Illegal code (0x10-0xEF, 0xF1-0xFF) on accept: mask unchanged, err set. err stays set until reset or an accepted LOAD with a legal code.
- Accepted LOAD with a legal index also clears err.
- Ack signalling:
  - ack is a 1-cycle pulse in the cycle after the update edge, for every accepted strobe, legal or illegal.
  - ack_toggle inverts on every accepted strobe.
- One update per strobe high period. A held-high strobe produces a single update; the next update needs strobe low for at least 1 clk as seen after the synchronizer.
- Read-back:
  - uo_out = uio_in[3] ? mask[15:8] : mask[7:0]. This is a combinational mux of the registered mask, with no added latency.
  - mask_zero = (mask == 0), combinational from the register.
  - err and ack are registered.
- Simultaneous events:
  - A byte-select change during an update edge shows the new mask in the selected byte on the following cycle.
  - Reset mid-handshake aborts the pending update. After release, a strobe still high is seen as a new rise once synchronized, because the delay flop reset to 0.
- uio_oe is fixed at 0xF0 and is not affected by ena or reset.

Test Plan:
- Reset, then LOAD code 0x05 with strobe held 4 cycles -> exactly one ack at edge SYNC_STAGES+1, mask=0x0020; with byte select 0 uo_out=0x20, with byte select 1 uo_out=0x00; mask_zero=0, ack_toggle=1.
- SET 0x0F, then SET 0x00, then TOGGLE 0x05 from mask 0x0020 -> mask 0x8021 -> 0x8001; byte select 1 gives uo_out=0x80.
- Illegal code 0x10 with SET -> ack pulses, mask unchanged, err=1. CLEAR 0x00 -> err stays 1. LOAD 0xF0 -> mask=0x0000, err=0, mask_zero=1.
- ena=0 during strobe with LOAD 0x03 -> no ack, ack_toggle unchanged, mask unchanged. Next strobe with ena=1 -> mask=0x0008.
- Assert rst_n low one cycle after strobe rise (before the update edge) -> all outputs at reset values. Strobe still high after release -> one update SYNC_STAGES edges after release.
- Back-to-back strobes with 1-cycle low gap (post-sync) -> two acks, ack_toggle returns to its original value, both ops applied in order.

Source files
------------

// File: rtl/tt_um_priority_decoder.sv
// rtl/tt_um_priority_decoder.sv - rebuilds a 16-bit mask from priority-encoder codes strobed in over uio
module tt_um_priority_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_LOAD   = 2'b11
  } op_e;

  localparam logic [7:0] CODE_NONE = 8'hF0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise;
  logic                   accept;
  logic [15:0]            mask_q;
  logic                   ack_q;
  logic                   ack_toggle_q;
  logic                   err_q;
  logic [15:0]            onehot;
  logic                   idx_legal;
  logic                   code_none;
  op_e                    op;
  logic                   unused_bits;

  assign unused_bits = &{1'b0, uio_in[7:4]};

  // Only the strobe is synchronized; code and op are held stable by the host until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uio_in[0]};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign accept    = rise & ena;
  assign onehot    = 16'h0001 << ui_in[3:0];
  assign idx_legal = (ui_in[7:4] == 4'h0);
  assign code_none = (ui_in == CODE_NONE);
  assign op        = op_e'(uio_in[2:1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q       <= 16'h0000;
      ack_q        <= 1'b0;
      ack_toggle_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        ack_toggle_q <= ~ack_toggle_q;
        if (idx_legal) begin
          unique case (op)
            OP_SET:    mask_q <= mask_q | onehot;
            OP_CLEAR:  mask_q <= mask_q & ~onehot;
            OP_TOGGLE: mask_q <= mask_q ^ onehot;
            OP_LOAD: begin
              mask_q <= onehot;
              err_q  <= 1'b0;
            end
          endcase
        end else if (code_none) begin
          // "No bit set" only has an effect through LOAD, which also recovers from an error.
          if (op == OP_LOAD) begin
            mask_q <= 16'h0000;
            err_q  <= 1'b0;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign uo_out  = uio_in[3] ? mask_q[15:8] : mask_q[7:0];
  assign uio_out = {err_q, (mask_q == 16'h0000), ack_toggle_q, ack_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// tb/tb_tt_um_priority_decoder.sv - directed self-checking bench for tt_um_priority_decoder
module tb_tt_um_priority_decoder;

  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks;
  int failures;

  tt_um_priority_decoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_mask(output logic [15:0] m);
    uio_in[3] = 1'b0;
    #1;
    m[7:0] = uo_out;
    uio_in[3] = 1'b1;
    #1;
    m[15:8] = uo_out;
    uio_in[3] = 1'b0;
    #1;
  endtask

  // Drives one strobe held for 'hold' cycles, then low long enough to clear the synchronizer.
  task automatic send(input logic [1:0] op, input logic [7:0] code, input int hold,
                      output int acks, output int first_ack);
    ui_in      = code;
    uio_in[2:1] = op;
    uio_in[0]  = 1'b1;
    acks       = 0;
    first_ack  = -1;
    for (int i = 1; i <= hold + SYNC_STAGES + 3; i++) begin
      tick();
      if (i == hold) uio_in[0] = 1'b0;
      if (uio_out[4]) begin
        acks++;
        if (first_ack < 0) first_ack = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (uio_out !== 8'h40) begin failures++; $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h40); end
    checks++;
    if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo_out got=%h exp=%h", uo_out, 8'h00); end
    checks++;
    if (uio_oe !== 8'hF0) begin failures++; $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'hF0); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int acks, first;
    logic [15:0] m;
    send(2'b11, 8'h05, 4, acks, first);
    checks++;
    if (acks !== 1) begin failures++; $display("FAIL load_ack_count got=%0d exp=1", acks); end
    checks++;
    if (first !== SYNC_STAGES + 1) begin failures++; $display("FAIL load_ack_time got=%0d exp=%0d", first, SYNC_STAGES + 1); end
    read_mask(m);
    checks++;
    if (m !== 16'h0020) begin failures++; $display("FAIL load_mask got=%h exp=%h", m, 16'h0020); end
    checks++;
    if (uio_out !== 8'h20) begin failures++; $display("FAIL load_status got=%h exp=%h", uio_out, 8'h20); end
    checks++;
    if (uio_oe !== 8'hF0) begin failures++; $display("FAIL run_uio_oe got=%h exp=%h", uio_oe, 8'hF0); end
  endtask

  task automatic test_set_toggle();
    int acks, first;
    logic [15:0] m;
    send(2'b00, 8'h0F, 3, acks, first);
    read_mask(m);
    checks++;
    if (m !== 16'h8020) begin failures++; $display("FAIL set15_mask got=%h exp=%h", m, 16'h8020); end
    send(2'b00, 8'h00, 3, acks, first);
    read_mask(m);
    checks++;
    if (m !== 16'h8021) begin failures++; $display("FAIL set0_mask got=%h exp=%h", m, 16'h8021); end
    send(2'b10, 8'h05, 3, acks, first);
    read_mask(m);
    checks++;
    if (m !== 16'h8001) begin failures++; $display("FAIL toggle5_mask got=%h exp=%h", m, 16'h8001); end
    uio_in[3] = 1'b1;
    #1;
    checks++;
    if (uo_out !== 8'h80) begin failures++; $display("FAIL hi_byte got=%h exp=%h", uo_out, 8'h80); end
    uio_in[3] = 1'b0;
    checks++;
    if (uio_out !== 8'h00) begin failures++; $display("FAIL set_toggle_status got=%h exp=%h", uio_out, 8'h00); end
  endtask

  task automatic test_error();
    int acks, first;
    logic [15:0] m;
    send(2'b00, 8'h10, 3, acks, first);
    checks++;
    if (acks !== 1) begin failures++; $display("FAIL illegal_ack got=%0d exp=1", acks); end
    read_mask(m);
    checks++;
    if (m !== 16'h8001) begin failures++; $display("FAIL illegal_mask got=%h exp=%h", m, 16'h8001); end
    checks++;
    if (uio_out !== 8'hA0) begin failures++; $display("FAIL illegal_status got=%h exp=%h", uio_out, 8'hA0); end
    send(2'b01, 8'h00, 3, acks, first);
    read_mask(m);
    checks++;
    if (m !== 16'h8000) begin failures++; $display("FAIL clear0_mask got=%h exp=%h", m, 16'h8000); end
    checks++;
    if (uio_out !== 8'h80) begin failures++; $display("FAIL err_sticky got=%h exp=%h", uio_out, 8'h80); end
    send(2'b11, 8'hF0, 3, acks, first);
    read_mask(m);
    checks++;
    if (m !== 16'h0000) begin failures++; $display("FAIL load_none_mask got=%h exp=%h", m, 16'h0000); end
    checks++;
    if (uio_out !== 8'h60) begin failures++; $display("FAIL load_none_status got=%h exp=%h", uio_out, 8'h60); end
  endtask

  task automatic test_ena();
    int acks, first;
    logic [15:0] m;
    ena = 1'b0;
    send(2'b11, 8'h03, 3, acks, first);
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL ena_low_ack got=%0d exp=0", acks); end
    read_mask(m);
    checks++;
    if (m !== 16'h0000) begin failures++; $display("FAIL ena_low_mask got=%h exp=%h", m, 16'h0000); end
    checks++;
    if (uio_out !== 8'h60) begin failures++; $display("FAIL ena_low_status got=%h exp=%h", uio_out, 8'h60); end
    ena = 1'b1;
    send(2'b11, 8'h03, 3, acks, first);
    read_mask(m);
    checks++;
    if (m !== 16'h0008) begin failures++; $display("FAIL ena_high_mask got=%h exp=%h", m, 16'h0008); end
    checks++;
    if (uio_out !== 8'h00) begin failures++; $display("FAIL ena_high_status got=%h exp=%h", uio_out, 8'h00); end
  endtask

  task automatic test_reset_mid();
    int acks, first;
    logic [15:0] m;
    ui_in       = 8'h07;
    uio_in[2:1] = 2'b00;
    uio_in[0]   = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (uio_out !== 8'h40) begin failures++; $display("FAIL mid_reset_uio_out got=%h exp=%h", uio_out, 8'h40); end
    checks++;
    if (uo_out !== 8'h00) begin failures++; $display("FAIL mid_reset_uo_out got=%h exp=%h", uo_out, 8'h00); end
    tick();
    tick();
    rst_n = 1'b1;
    acks  = 0;
    first = -1;
    for (int i = 1; i <= SYNC_STAGES + 5; i++) begin
      tick();
      if (i == SYNC_STAGES + 2) uio_in[0] = 1'b0;
      if (uio_out[4]) begin
        acks++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (acks !== 1) begin failures++; $display("FAIL post_reset_ack_count got=%0d exp=1", acks); end
    checks++;
    if (first !== SYNC_STAGES + 1) begin failures++; $display("FAIL post_reset_ack_time got=%0d exp=%0d", first, SYNC_STAGES + 1); end
    read_mask(m);
    checks++;
    if (m !== 16'h0080) begin failures++; $display("FAIL post_reset_mask got=%h exp=%h", m, 16'h0080); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acks;
    int ack_at [2];
    logic [7:0] lo_after_first;
    logic [15:0] m;
    ui_in       = 8'h01;
    uio_in[2:1] = 2'b00;
    uio_in[0]   = 1'b1;
    acks = 0;
    ack_at[0] = -1;
    ack_at[1] = -1;
    lo_after_first = 8'hXX;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (uio_out[4]) begin
        if (acks < 2) ack_at[acks] = i;
        acks++;
      end
      if (i == 3) begin
        lo_after_first = uo_out;
        uio_in[0]   = 1'b0;
        ui_in       = 8'h07;
        uio_in[2:1] = 2'b10;
      end
      if (i == 4) uio_in[0] = 1'b1;
      if (i == 8) uio_in[0] = 1'b0;
    end
    checks++;
    if (acks !== 2) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=2", acks); end
    checks++;
    if (ack_at[0] !== 3 || ack_at[1] !== 7) begin
      failures++;
      $display("FAIL b2b_ack_times got=%0d,%0d exp=3,7", ack_at[0], ack_at[1]);
    end
    checks++;
    if (lo_after_first !== 8'h82) begin failures++; $display("FAIL b2b_first_mask got=%h exp=%h", lo_after_first, 8'h82); end
    read_mask(m);
    checks++;
    if (m !== 16'h0002) begin failures++; $display("FAIL b2b_final_mask got=%h exp=%h", m, 16'h0002); end
    checks++;
    if (uio_out !== 8'h20) begin failures++; $display("FAIL b2b_status got=%h exp=%h", uio_out, 8'h20); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    test_reset();
    test_load();
    test_set_toggle();
    test_error();
    test_ena();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
